// File: rtl/mul_unit_pkg.sv
// Shared definitions for the iterative M-extension multiply unit:
// funct3 encodings, FSM state encoding and funct3 decode helpers.
package mul_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Returns {rs1_signed, rs2_signed}; the 1xx encodings behave as MUL.
  function automatic logic [1:0] f3_signs(input logic [2:0] f3);
    logic [1:0] s;
    case (f3)
      F3_MULH:   s = 2'b11;
      F3_MULHSU: s = 2'b10;
      F3_MULHU:  s = 2'b00;
      default:   s = 2'b00;
    endcase
    return s;
  endfunction

  function automatic logic f3_low_word(input logic [2:0] f3);
    return f3[2] | (f3 == F3_MUL);
  endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Unsigned shift-add engine: retires BITS_PER_CYCLE multiplier bits per step
// into a 2*XLEN accumulator and flags the final step.
module mul_shift_add_core
  import mul_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [XLEN:0]     mcand_mag,
  input  logic [XLEN-1:0]   mplier_mag,
  output logic [2*XLEN-1:0] product,
  output logic              last
);

  localparam int PW    = 2 * XLEN;
  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  logic [PW-1:0]    acc_r;
  logic [PW-1:0]    mcand_r;
  logic [XLEN-1:0]  mplier_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PW-1:0]    partial_s;

  // Sum of the multiplicand shifted by each set multiplier bit in this slice.
  always_comb begin
    partial_s = {PW{1'b0}};
    for (int b = 0; b < BITS_PER_CYCLE; b++) begin
      if (mplier_r[b]) begin
        partial_s = partial_s + (mcand_r << b);
      end else begin
        partial_s = partial_s;
      end
    end
  end

  // Accumulator, operand shifters and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r    <= {PW{1'b0}};
      mcand_r  <= {PW{1'b0}};
      mplier_r <= {XLEN{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (load) begin
      acc_r    <= {PW{1'b0}};
      mcand_r  <= {{(PW - XLEN - 1){1'b0}}, mcand_mag};
      mplier_r <= mplier_mag;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (step) begin
      acc_r    <= acc_r + partial_s;
      mcand_r  <= mcand_r << BITS_PER_CYCLE;
      mplier_r <= mplier_r >> BITS_PER_CYCLE;
      cnt_r    <= cnt_r + CNT_W'(1);
    end
  end

  assign product = acc_r;
  assign last    = (cnt_r == LAST_CNT);

endmodule

// File: rtl/mul_unit.sv
// Iterative RV M-extension multiplier (MUL/MULH/MULHSU/MULHU) with a
// start/done handshake, abort, and a one-entry full-product cache.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int CACHE_EN       = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_kill,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_res
);

  localparam int PW = 2 * XLEN;

  state_e          state_r;
  logic            res_lo_r;
  logic            neg_r;
  logic [1:0]      signs_r;
  logic [XLEN-1:0] rs1_r;
  logic [XLEN-1:0] rs2_r;

  logic            cache_valid_r;
  logic [1:0]      cache_signs_r;
  logic [XLEN-1:0] cache_rs1_r;
  logic [XLEN-1:0] cache_rs2_r;
  logic [PW-1:0]   cache_prod_r;

  logic [1:0]      signs_s;
  logic            low_word_s;
  logic            rs1_neg_s;
  logic            rs2_neg_s;
  logic [XLEN:0]   mcand_mag_s;
  logic [XLEN-1:0] mplier_mag_s;
  logic            accept_s;
  logic            hit_s;
  logic [XLEN-1:0] hit_res_s;
  logic            core_load_s;
  logic            core_step_s;
  logic            core_last_s;
  logic [PW-1:0]   core_prod_s;
  logic [PW-1:0]   signed_prod_s;
  logic [XLEN-1:0] calc_res_s;

  // Request decode: signedness, magnitudes and cache lookup on the live ports.
  always_comb begin
    signs_s    = f3_signs(i_f3);
    low_word_s = f3_low_word(i_f3);
    rs1_neg_s  = signs_s[1] & i_rs1[XLEN-1];
    rs2_neg_s  = signs_s[0] & i_rs2[XLEN-1];
    // One extra bit keeps the most-negative multiplicand's magnitude exact.
    if (rs1_neg_s) begin
      mcand_mag_s = {(XLEN + 1){1'b0}} - {1'b1, i_rs1};
    end else begin
      mcand_mag_s = {1'b0, i_rs1};
    end
    if (rs2_neg_s) begin
      mplier_mag_s = {XLEN{1'b0}} - i_rs2;
    end else begin
      mplier_mag_s = i_rs2;
    end
    accept_s = (state_r == ST_IDLE) & i_start & ~i_kill;
    hit_s    = (CACHE_EN != 0) & cache_valid_r
             & (i_rs1 == cache_rs1_r) & (i_rs2 == cache_rs2_r)
             & (low_word_s | (signs_s == cache_signs_r));
    if (low_word_s) begin
      hit_res_s = cache_prod_r[XLEN-1:0];
    end else begin
      hit_res_s = cache_prod_r[PW-1:XLEN];
    end
    core_load_s = accept_s & ~hit_s;
    core_step_s = (state_r == ST_CALC) & ~i_kill;
  end

  mul_shift_add_core #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .clk        (i_clk),
    .rst        (i_rst),
    .load       (core_load_s),
    .step       (core_step_s),
    .mcand_mag  (mcand_mag_s),
    .mplier_mag (mplier_mag_s),
    .product    (core_prod_s),
    .last       (core_last_s)
  );

  // Sign fix-up of the unsigned product and result word select.
  always_comb begin
    if (neg_r) begin
      signed_prod_s = {PW{1'b0}} - core_prod_s;
    end else begin
      signed_prod_s = core_prod_s;
    end
    if (res_lo_r) begin
      calc_res_s = signed_prod_s[XLEN-1:0];
    end else begin
      calc_res_s = signed_prod_s[PW-1:XLEN];
    end
  end

  // Control FSM, operand latches, product cache and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r       <= ST_IDLE;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_res         <= {XLEN{1'b0}};
      res_lo_r      <= 1'b0;
      neg_r         <= 1'b0;
      signs_r       <= 2'b00;
      rs1_r         <= {XLEN{1'b0}};
      rs2_r         <= {XLEN{1'b0}};
      cache_valid_r <= 1'b0;
      cache_signs_r <= 2'b00;
      cache_rs1_r   <= {XLEN{1'b0}};
      cache_rs2_r   <= {XLEN{1'b0}};
      cache_prod_r  <= {PW{1'b0}};
    end else begin
      o_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            res_lo_r <= low_word_s;
            neg_r    <= rs1_neg_s ^ rs2_neg_s;
            signs_r  <= signs_s;
            rs1_r    <= i_rs1;
            rs2_r    <= i_rs2;
            if (hit_s) begin
              state_r <= ST_DONE;
              o_done  <= 1'b1;
              o_res   <= hit_res_s;
              o_busy  <= 1'b0;
            end else begin
              state_r <= ST_CALC;
              o_busy  <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          if (i_kill) begin
            state_r <= ST_IDLE;
            o_busy  <= 1'b0;
          end else if (core_last_s) begin
            state_r <= ST_SIGN;
          end
        end
        ST_SIGN: begin
          if (i_kill) begin
            state_r <= ST_IDLE;
            o_busy  <= 1'b0;
          end else begin
            state_r       <= ST_DONE;
            o_busy        <= 1'b0;
            o_done        <= 1'b1;
            o_res         <= calc_res_s;
            cache_valid_r <= 1'b1;
            cache_signs_r <= signs_r;
            cache_rs1_r   <= rs1_r;
            cache_rs2_r   <= rs2_r;
            cache_prod_r  <= signed_prod_s;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit (XLEN=32, one bit per cycle): vector table,
// randomised cache pairs, and kill/re-start/reset sequences with a result scoreboard.
module tb_mul_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam int MISS_LAT = 34;
  localparam int NVEC     = 13;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res;
  } sb_t;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic        i_kill;
  logic [2:0]  i_f3;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_res;

  int          n_cmp;
  int          n_err;
  sb_t         sb_q[$];
  sb_t         mon_e;
  logic [31:0] last_res;
  vec_t        vecs[NVEC];

  mul_unit #(
    .XLEN           (32),
    .BITS_PER_CYCLE (1),
    .CACHE_EN       (1)
  ) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_kill  (i_kill),
    .i_f3    (i_f3),
    .i_rs1   (i_rs1),
    .i_rs2   (i_rs2),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_res   (o_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference result from full 64-bit extended multiplication.
  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = {32'd0, a};
    eb = {32'd0, b};
    if (f3 == OP_MULH || f3 == OP_MULHSU) ea = {{32{a[31]}}, a};
    if (f3 == OP_MULH) eb = {{32{b[31]}}, b};
    p = ea * eb;
    return (f3[2] || f3 == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  // Every done pulse must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (o_done === 1'b1) begin
      check("done_expected", {63'd0, sb_q.size() > 0}, 64'd1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_res"}, {32'd0, o_res}, {32'd0, mon_e.res});
      end
    end
  end

  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int lat);
    int   cyc;
    logic busy_bad;
    sb_t  e;
    @(negedge clk);
    i_start = 1'b1;
    i_f3    = f3;
    i_rs1   = a;
    i_rs2   = b;
    e.name  = name;
    e.res   = exp_res;
    sb_q.push_back(e);
    last_res = exp_res;
    @(negedge clk);
    i_start  = 1'b0;
    cyc      = 1;
    busy_bad = 1'b0;
    while (o_done !== 1'b1 && cyc < 100) begin
      if (o_busy !== 1'b1) busy_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check({name, "_lat"}, cyc, lat);
    check({name, "_busy"}, {63'd0, busy_bad}, 64'd0);
    check({name, "_busy_at_done"}, {63'd0, o_busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;
    sb_t  e;

    n_cmp = 0;
    n_err = 0;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_kill = 1'b0;
    i_f3 = OP_MUL;
    i_rs1 = 32'd0;
    i_rs2 = 32'd0;
    last_res = 32'd0;

    vecs[0]  = '{"mul_7_m3",       OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MISS_LAT};
    vecs[1]  = '{"mulh_min_min",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MISS_LAT};
    vecs[2]  = '{"mul_min_hit",    OP_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 1};
    vecs[3]  = '{"mulhsu_m1",      OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MISS_LAT};
    vecs[4]  = '{"mulhu_miss",     OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MISS_LAT};
    vecs[5]  = '{"mulhu_hit",      OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1};
    vecs[6]  = '{"mul_lo_hit",     OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1};
    vecs[7]  = '{"mulh_min_max",   OP_MULH,   32'h80000000, 32'h7FFFFFFF, 32'hC0000000, MISS_LAT};
    vecs[8]  = '{"f3_100_as_mul",  3'b100,    32'h12345678, 32'h00000010, 32'h23456780, MISS_LAT};
    vecs[9]  = '{"mul_by_zero",    OP_MUL,    32'hDEADBEEF, 32'h00000000, 32'h00000000, MISS_LAT};
    vecs[10] = '{"mulhu_min",      OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, MISS_LAT};
    vecs[11] = '{"mulh_m1_m1",     OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MISS_LAT};
    vecs[12] = '{"mulhsu_min",     OP_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000, MISS_LAT};

    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    check("rst_done", {63'd0, o_done}, 64'd0);
    check("rst_res", {32'd0, o_res}, 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      do_op(vecs[i].name, vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].res, vecs[i].lat);
    end

    // Random high-word op followed by a MUL on the same operands (cache hit).
    for (int i = 0; i < 4; i++) begin
      rf3 = 3'($urandom_range(1, 3));
      ra  = $urandom();
      rb  = $urandom();
      do_op("rand_miss", rf3, ra, rb, ref_mul(rf3, ra, rb), MISS_LAT);
      do_op("rand_hit", OP_MUL, ra, rb, ref_mul(OP_MUL, ra, rb), 1);
    end

    // Kill during CALC: no done, busy drops, result held.
    @(negedge clk);
    i_start = 1'b1; i_f3 = OP_MUL; i_rs1 = 32'd5; i_rs2 = 32'd6;
    @(negedge clk);
    i_start = 1'b0;
    repeat (9) @(negedge clk);
    i_kill = 1'b1;
    @(negedge clk);
    i_kill = 1'b0;
    check("kill_busy", {63'd0, o_busy}, 64'd0);
    check("kill_done", {63'd0, o_done}, 64'd0);
    check("kill_res_held", {32'd0, o_res}, {32'd0, last_res});
    repeat (40) @(negedge clk);
    do_op("kill_redo", OP_MUL, 32'd5, 32'd6, 32'd30, MISS_LAT);

    // Kill together with start in IDLE drops the (otherwise cache-hitting) start.
    @(negedge clk);
    i_start = 1'b1; i_kill = 1'b1; i_f3 = OP_MUL; i_rs1 = 32'd5; i_rs2 = 32'd6;
    @(negedge clk);
    i_start = 1'b0; i_kill = 1'b0;
    check("kill_start_done", {63'd0, o_done}, 64'd0);
    check("kill_start_busy", {63'd0, o_busy}, 64'd0);
    repeat (5) @(negedge clk);

    // Start re-pulsed during CALC is ignored; one result delivered.
    @(negedge clk);
    i_start = 1'b1; i_f3 = OP_MUL; i_rs1 = 32'd3; i_rs2 = 32'd4;
    e.name = "repulse"; e.res = 32'd12;
    sb_q.push_back(e);
    @(negedge clk);
    i_start = 1'b0;
    cyc = 1;
    while (o_done !== 1'b1 && cyc < 100) begin
      if (cyc == 5) begin
        i_start = 1'b1; i_rs1 = 32'd1; i_rs2 = 32'd1;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0;
    check("repulse_lat", cyc, MISS_LAT);
    repeat (40) @(negedge clk);

    // Reset mid-operation clears outputs and the cache.
    do_op("rst_pre", OP_MULHU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, MISS_LAT);
    @(negedge clk);
    i_start = 1'b1; i_f3 = OP_MULHU; i_rs1 = 32'h00001234; i_rs2 = 32'h00005678;
    @(negedge clk);
    i_start = 1'b0;
    repeat (19) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("midrst_busy", {63'd0, o_busy}, 64'd0);
    check("midrst_done", {63'd0, o_done}, 64'd0);
    check("midrst_res", {32'd0, o_res}, 64'd0);
    repeat (40) @(negedge clk);
    do_op("rst_repeat", OP_MULHU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, MISS_LAT);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Parametrised, iterative RV M-extension multiply unit for MUL/MULH/MULHSU/MULHU; successor to the fixed 32-bit multiply wrapper.
- Sits in the execute stage beside the divider, behind the same start/done handshake.
- Adds configurable XLEN, bits retired per cycle, abort, a busy flag, and a one-entry product cache: a MULH*/MUL pair on the same operands returns in one cycle.

Parameters:
- XLEN, 32, operand/result width; must be even and at least 8.
- BITS_PER_CYCLE, 1, multiplier bits retired per CALC cycle; must divide XLEN exactly. N = XLEN/BITS_PER_CYCLE.
- CACHE_EN, 1, 1 enables the one-entry product cache; 0 means every op takes the full latency.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  request; accepted only when o_busy=0
- i_kill  in  1  abort the in-flight op (pipeline flush)
- i_f3  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx treated as MUL
- i_rs1  in  XLEN  multiplicand
- i_rs2  in  XLEN  multiplier
- o_busy  out  1  high from the cycle after accept until done
- o_done  out  1  one-cycle pulse; o_res valid in the same cycle
- o_res  out  XLEN  result; held until the next done

Behaviour:
- Reset state:
  - state=IDLE; o_busy=0, o_done=0, o_res=0.
  - Cache valid bit cleared.
- States: IDLE, CALC, SIGN, DONE.
- Accept: i_start=1 while IDLE (not busy).
  - Latch f3, operands, and sign flags: rs1 signed for MULH/MULHSU; rs2 signed for MULH only.
  - Latch magnitude operands (two's-complement absolute value if signed and the MSB is set).
  - Latch neg = sign(rs1) XOR sign(rs2).
- Cache hit: CACHE_EN=1, cache valid, rs1/rs2 equal the cached operands, and either:
  - the op is MUL (low word is signedness-independent), or
  - the op's signedness pair equals the cached pair.
  - On a hit: state -> DONE; o_done pulses the cycle after accept (latency 1).
- Miss: state -> CALC.
  - Each CALC cycle performs an unsigned shift-add of BITS_PER_CYCLE multiplier bits into a 2*XLEN accumulator.
  - Step counter runs 0..N-1.
- After N CALC cycles: state -> SIGN, a single cycle that negates the 2*XLEN product if neg is set.
- SIGN -> DONE:
  - Write the cache (operands, signedness pair, full product, valid=1).
  - Drive o_res: product[XLEN-1:0] for MUL, product[2XLEN-1:XLEN] otherwise.
  - o_done=1.
- Miss latency: o_done is high in cycle N+2 after the accept edge (XLEN=32, BPC=1: cycle 34).
- DONE -> IDLE unconditionally. A new i_start in the DONE cycle is ignored; o_busy drops to 0 in the DONE cycle.
- i_start while busy: ignored, no side effects.
- i_kill:
  - In CALC or SIGN: state -> IDLE next cycle, no o_done, cache unchanged, o_res unchanged.
  - In IDLE or DONE: no effect. A DONE-cycle pulse still completes.
  - i_kill together with i_start in IDLE: start is dropped.
- i_rst mid-operation: identical to the reset state; the cache is invalidated.
- Boundary values:
  - Most-negative operands are handled by using XLEN+1-bit magnitudes, with no overflow.
  - Multiplier value 0 still takes the full N cycles (fixed latency; no early exit).

Decomposition:
- Shared header (alongside the M-ISA funct3 defines) holds:
  - the funct3 constants MUL/MULH/MULHSU/MULHU;
  - state encodings IDLE=2'd0, CALC=2'd1, SIGN=2'd2, DONE=2'd3.
- One natural sub-module, mul_shift_add_core: the accumulator, step counter, and magnitude datapath.
  - Inputs: load, magnitudes.
  - Outputs: unsigned 2*XLEN product, last-step flag.
- mul_unit itself keeps the FSM, sign logic, cache, and result select.

Test Plan (XLEN=32, BITS_PER_CYCLE=1):
- MUL rs1=7, rs2=0xFFFFFFFD (-3) -> o_done in cycle 34 after accept, o_res=0xFFFFFFEB; o_busy high for cycles 1..33.
- MULH rs1=rs2=0x80000000 -> o_res=0x40000000. A following MUL with the same operands hits the cache: o_done the next cycle, o_res=0x00000000.
- MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> o_res=0xFFFFFFFF. A following MULHU with the same operands misses (signedness differs) and after 34 cycles gives o_res=0xFFFFFFFE.
- Start MUL 5*6, assert i_kill in cycle 10 -> no o_done, o_busy=0 next cycle. An immediate MUL 5*6 misses, takes 34 cycles, o_res=30.
- i_start re-pulsed during CALC with rs1=1, rs2=1 -> ignored; the original result (MUL 3*4=12) is delivered once.
- i_rst asserted in cycle 20 of a MULHU -> all outputs 0 next cycle, no o_done. A repeat of the prior op misses (cache cleared).
